// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the async_fifo read-side drain controller:
// state encoding, default widths and output buffer depth.
package fifo_rd_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;
    localparam int BUF_DEPTH  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/out_skid_buf.sv
// 3-entry in-order output buffer; the head always sits in slot 0.
// Ports: push/push_data write, pop removes head, occ = entries held, head = oldest.
module out_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic              do_pop;
    logic              do_push;
    logic [1:0]        wr_idx;

    always_comb begin
        do_pop  = pop && (occ != 2'd0);
        do_push = push && ((occ != 2'(BUF_DEPTH)) || do_pop);
        // With a simultaneous pop everything shifts down one slot first.
        wr_idx  = do_pop ? (occ - 2'd1) : occ;
        head    = mem[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            // Placed after the shift so the new word wins its slot.
            if (do_push) begin
                mem[wr_idx] <= push_data;
            end
            unique case ({do_push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_drain_reader.sv
// Read-domain drain controller: pulls words from async_fifo and streams them out.
// Ports: start/abort/drain_len control, fifo_empty/read_enable/read_data to the
// FIFO, out_data/out_valid/out_ready stream, words_read/busy/done status.
module fifo_drain_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              rd_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  drain_len,
    input  logic              fifo_empty,
    output logic              read_enable,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  words_read,
    output logic              busy,
    output logic              done
);

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] issued;
    logic             inflight;
    logic [1:0]       occ;
    logic             pop;
    logic             room;
    logic             below_len;
    logic             flush_done;

    out_skid_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (rd_clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (read_data),
        .pop       (pop),
        .occ       (occ),
        .head      (out_data)
    );

    always_comb begin
        // Reserve a slot for the word already in flight so the buffer
        // can never overflow, independent of out_ready.
        room        = ({1'b0, occ} + {2'b00, inflight}) < 3'(BUF_DEPTH);
        below_len   = (len_q == '0) || (issued < len_q);
        read_enable = (state == DRAIN) && !fifo_empty && room &&
                      !abort && below_len;
        out_valid   = (occ != 2'd0);
        pop         = out_valid && out_ready;
        flush_done  = (state == FLUSH) && !inflight && (occ == 2'd0);
        done        = flush_done;
        busy        = (state != IDLE);
    end

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            issued     <= '0;
            inflight   <= 1'b0;
            words_read <= '0;
        end else begin
            inflight <= read_enable;
            if (read_enable) begin
                issued <= issued + CNT_W'(1);
            end
            if (pop) begin
                words_read <= words_read + CNT_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= DRAIN;
                        len_q      <= drain_len;
                        issued     <= '0;
                        words_read <= '0;
                    end
                end
                DRAIN: begin
                    if (abort || ((len_q != '0) && (issued == len_q))) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Directed bench for fifo_drain_reader: a behavioural FIFO source, an output
// monitor, a cycle table for the basic drain and hand sequences for corners.
module tb_fifo_drain_reader;

    logic        rd_clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] drain_len;
    logic        fifo_empty;
    logic        read_enable;
    logic [7:0]  read_data = 8'h00;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] words_read;
    logic        busy;
    logic        done;

    int nchk = 0;
    int nerr = 0;

    always #5 rd_clk = ~rd_clk;

    fifo_drain_reader #(
        .DATA_W (8),
        .CNT_W  (16)
    ) dut (
        .rd_clk      (rd_clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .drain_len   (drain_len),
        .fifo_empty  (fifo_empty),
        .read_enable (read_enable),
        .read_data   (read_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .words_read  (words_read),
        .busy        (busy),
        .done        (done)
    );

    // Behavioural source FIFO: one-cycle read latency.
    logic [7:0] fmem [0:255];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic fifo_clr = 1'b0;
    logic force_empty = 1'b0;
    logic toggle_en = 1'b0;
    int   re_count = 0;
    int   empty_viol = 0;

    assign fifo_empty = (wr_ptr == rd_ptr) || force_empty;

    always @(posedge rd_clk) begin
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end else if (read_enable) begin
            read_data <= fmem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
        if (read_enable) re_count <= re_count + 1;
        if (read_enable && fifo_empty) empty_viol <= empty_viol + 1;
    end

    always @(posedge rd_clk) begin
        force_empty <= toggle_en ? ~force_empty : 1'b0;
    end

    // Output monitor.
    logic [7:0] cap [0:255];
    int cap_n = 0;

    always @(posedge rd_clk) begin
        if (out_valid && out_ready) begin
            cap[cap_n] <= out_data;
            cap_n      <= cap_n + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic flush_fifo();
        next_cycle();
        fifo_clr = 1'b1;
        next_cycle();
        fifo_clr = 1'b0;
    endtask

    task automatic load(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            fmem[wr_ptr] = 8'(base + k);
            wr_ptr++;
        end
    endtask

    task automatic wait_done(input int maxc, input string nm);
        int n;
        n = 0;
        @(negedge rd_clk);
        while (!done && n < maxc) begin
            @(negedge rd_clk);
            n++;
        end
        check(nm, 32'(done), 32'd1);
    endtask

    task automatic check_caps(input string nm, input int base,
                              input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            check(nm, 32'(cap[base+k]), 32'(8'(first + k)));
        end
    endtask

    typedef struct {
        logic        st;
        logic [15:0] len;
        logic        rdy;
        logic        re;
        logic        vld;
        logic [7:0]  dat;
        logic        bsy;
        logic        dn;
        logic [15:0] wr;
    } vec_t;

    vec_t tbl [7];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int r0;
        int c0;
        int hi;

        // st len rdy | re vld dat bsy dn wr
        tbl[0] = '{1'b1, 16'd2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
        tbl[1] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0};
        tbl[2] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 8'hCA, 1'b1, 1'b0, 16'd0};
        tbl[4] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 16'd1};
        tbl[5] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'd2};
        tbl[6] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd2};

        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        drain_len = 16'd0;
        out_ready = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge rd_clk);
        check("reset_outputs",
              32'({read_enable, out_valid, busy, done, out_data, words_read}),
              32'd0);
        next_cycle();
        reset = 1'b0;

        // Basic two-word drain, cycle by cycle.
        flush_fifo();
        fmem[wr_ptr] = 8'hCA;
        wr_ptr++;
        fmem[wr_ptr] = 8'hAA;
        wr_ptr++;
        r0 = re_count;
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            start     = tbl[i].st;
            drain_len = tbl[i].len;
            out_ready = tbl[i].rdy;
            @(negedge rd_clk);
            check($sformatf("table_row%0d", i),
                  32'({read_enable, out_valid, busy, done, words_read}),
                  32'({tbl[i].re, tbl[i].vld, tbl[i].bsy, tbl[i].dn, tbl[i].wr}));
            if (tbl[i].vld) begin
                check($sformatf("table_data%0d", i), 32'(out_data),
                      32'(tbl[i].dat));
            end
        end
        check("t2_reads", 32'(re_count - r0), 32'd2);

        // Continuous drain of 10 words, then abort.
        flush_fifo();
        load(8'h30, 10);
        r0 = re_count;
        c0 = cap_n;
        next_cycle();
        start     = 1'b1;
        drain_len = 16'd0;
        out_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge rd_clk);
            hi += int'(read_enable);
            next_cycle();
        end
        check("t3_consecutive_reads", 32'(hi), 32'd10);
        @(negedge rd_clk);
        check("t3_re_low_empty", {31'd0, read_enable}, 32'd0);
        check("t3_busy_continuous", {31'd0, busy}, 32'd1);
        next_cycle();
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        wait_done(20, "t3_done");
        check("t3_words", 32'(words_read), 32'd10);
        check("t3_reads", 32'(re_count - r0), 32'd10);
        check_caps("t3_data", c0, 8'h30, 10);

        // Backpressure: buffer fills at 3, then resumes.
        flush_fifo();
        load(8'h50, 7);
        r0 = re_count;
        c0 = cap_n;
        next_cycle();
        start     = 1'b1;
        drain_len = 16'd5;
        out_ready = 1'b0;
        next_cycle();
        start = 1'b0;
        repeat (5) next_cycle();
        @(negedge rd_clk);
        check("t4_reads_blocked", 32'(re_count - r0), 32'd3);
        check("t4_re_low_full", {31'd0, read_enable}, 32'd0);
        check("t4_head_held", 32'({out_valid, out_data}), 32'h150);
        next_cycle();
        out_ready = 1'b1;
        wait_done(30, "t4_done");
        check("t4_words", 32'(words_read), 32'd5);
        check("t4_reads", 32'(re_count - r0), 32'd5);
        check("t4_fifo_left", 32'(wr_ptr - rd_ptr), 32'd2);
        check_caps("t4_data", c0, 8'h50, 5);

        // Abort right after the second read of an 8-word drain.
        flush_fifo();
        load(8'h60, 8);
        r0 = re_count;
        c0 = cap_n;
        next_cycle();
        start     = 1'b1;
        drain_len = 16'd8;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        abort = 1'b1;
        @(negedge rd_clk);
        check("t5_re_suppressed", {31'd0, read_enable}, 32'd0);
        next_cycle();
        abort = 1'b0;
        wait_done(20, "t5_done");
        check("t5_words", 32'(words_read), 32'd2);
        check("t5_reads", 32'(re_count - r0), 32'd2);
        check("t5_fifo_left", 32'(wr_ptr - rd_ptr), 32'd6);
        check_caps("t5_data", c0, 8'h60, 2);

        // Abort in IDLE is ignored.
        next_cycle();
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        @(negedge rd_clk);
        check("idle_abort_ignored", {31'd0, busy}, 32'd0);

        // start+abort in IDLE, restart during DRAIN, toggling fifo_empty.
        flush_fifo();
        load(8'h70, 6);
        r0 = re_count;
        c0 = cap_n;
        next_cycle();
        start     = 1'b1;
        abort     = 1'b1;
        drain_len = 16'd4;
        next_cycle();
        start     = 1'b0;
        abort     = 1'b0;
        toggle_en = 1'b1;
        next_cycle();
        start     = 1'b1;
        drain_len = 16'd6;
        next_cycle();
        start = 1'b0;
        wait_done(60, "t6_done");
        check("t6_words", 32'(words_read), 32'd4);
        check("t6_reads", 32'(re_count - r0), 32'd4);
        check("t6_fifo_left", 32'(wr_ptr - rd_ptr), 32'd2);
        check_caps("t6_data", c0, 8'h70, 4);
        next_cycle();
        toggle_en = 1'b0;
        next_cycle();

        // Reset while the buffer holds two words and one read is in flight.
        flush_fifo();
        load(8'h11, 4);
        next_cycle();
        start     = 1'b1;
        drain_len = 16'd0;
        out_ready = 1'b0;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        reset = 1'b1;
        #1;
        check("rst_async",
              32'({read_enable, out_valid, busy, done, out_data, words_read}),
              32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        r0 = re_count;
        c0 = cap_n;
        next_cycle();
        start     = 1'b1;
        drain_len = 16'd1;
        out_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_done(20, "t1_done");
        check("t1_words", 32'(words_read), 32'd1);
        check("t1_reads", 32'(re_count - r0), 32'd1);
        check_caps("t1_data", c0, 8'h14, 1);
        next_cycle();
        @(negedge rd_clk);
        check("t1_idle", {31'd0, busy}, 32'd0);

        check("empty_violations", 32'(empty_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
